// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream handshake, program-memory write port and
// load status between the host link and the program loader.
//   master : host / byte source side (drives Start, ByteIn, ByteValid)
//   slave  : program_loader side
interface program_loader_if #(
  parameter int DATA_WIDTH = 32
);
  // Host byte stream
  logic                  Start;
  logic [7:0]            ByteIn;
  logic                  ByteValid;
  logic                  ByteReady;

  // Program memory write port
  logic                  MemWrite;
  logic [DATA_WIDTH-1:0] WriteAddress;
  logic [DATA_WIDTH-1:0] WriteData;

  // Load status towards the CPU / host
  logic                  CpuHold;
  logic                  Done;
  logic                  Error;

  modport master (
    output Start, ByteIn, ByteValid,
    input  ByteReady, MemWrite, WriteAddress, WriteData, CpuHold, Done, Error
  );

  modport slave (
    input  Start, ByteIn, ByteValid,
    output ByteReady, MemWrite, WriteAddress, WriteData, CpuHold, Done, Error
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: receives a program as a byte stream (length byte, then
// little-endian 32-bit words), writes each assembled word to sequential
// program-memory addresses and holds the CPU while loading. Done / Error are
// sticky until the next Start.
//
// Optional feature: define PROGLOADER_CHECKSUM_EN to expect a trailing
// checksum byte equal to the XOR of all data bytes (length byte excluded).
// Without it the last word write goes straight to DONE.
//
// The loader never reads or erases the program memory; words written before
// an error or reset stay where they are.
module program_loader #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic             clk,
  input  logic             reset,   // asynchronous, active-low
  program_loader_if.slave  bus
);

  localparam int         IDX_W   = $clog2(MEMORY_DEPTH + 1);
  localparam logic [7:0] MAX_LEN = 8'(MEMORY_DEPTH);

`ifdef PROGLOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;
`endif

  state_t                r_state;
  state_t                w_state_next;

  logic [IDX_W-1:0]      r_len;        // word count of the current load
  logic [IDX_W-1:0]      r_word_idx;   // index of the word being assembled
  logic [IDX_W-1:0]      w_idx_inc;
  logic [1:0]            r_byte_cnt;   // byte lane within the current word
  logic [DATA_WIDTH-1:0] r_write_data;
`ifdef PROGLOADER_CHECKSUM_EN
  logic [7:0]            r_xor;        // running XOR of the data bytes
`endif

  logic                  w_byte_ready;
  logic                  w_accept;
  logic                  w_mem_write;
  logic                  w_cpu_hold;
  logic                  w_done;
  logic                  w_error;
  logic                  w_len_bad;

  assign w_idx_inc = r_word_idx + IDX_W'(1);
  assign w_accept  = bus.ByteValid && w_byte_ready;
  assign w_len_bad = (bus.ByteIn == 8'd0) || (bus.ByteIn > MAX_LEN);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave it
    // unassigned and infer a latch.
    w_state_next = r_state;
    w_byte_ready = 1'b0;
    w_mem_write  = 1'b0;
    w_cpu_hold   = 1'b0;
    w_done       = 1'b0;
    w_error      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.Start) w_state_next = S_LEN;
      end
      S_LEN: begin
        w_byte_ready = 1'b1;
        w_cpu_hold   = 1'b1;
        if (w_accept) w_state_next = w_len_bad ? S_ERROR : S_DATA;
      end
      S_DATA: begin
        w_byte_ready = 1'b1;
        w_cpu_hold   = 1'b1;
        if (w_accept && (r_byte_cnt == 2'd3)) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        w_mem_write = 1'b1;
        w_cpu_hold  = 1'b1;
        if (w_idx_inc == r_len) begin
`ifdef PROGLOADER_CHECKSUM_EN
          w_state_next = S_CHECK;
`else
          w_state_next = S_DONE;
`endif
        end else begin
          w_state_next = S_DATA;
        end
      end
`ifdef PROGLOADER_CHECKSUM_EN
      S_CHECK: begin
        w_byte_ready = 1'b1;
        w_cpu_hold   = 1'b1;
        if (w_accept) w_state_next = (bus.ByteIn == r_xor) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE: begin
        w_done = 1'b1;
        if (bus.Start) w_state_next = S_LEN;
      end
      S_ERROR: begin
        w_error    = 1'b1;
        w_cpu_hold = 1'b1;
        if (bus.Start) w_state_next = S_LEN;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Length latch, word/byte counters, word assembly and checksum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len        <= '0;
      r_word_idx   <= '0;
      r_byte_cnt   <= '0;
      r_write_data <= '0;
`ifdef PROGLOADER_CHECKSUM_EN
      r_xor        <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          // Restart the address from 0 as soon as a new load begins.
          if (bus.Start) begin
            r_word_idx <= '0;
            r_byte_cnt <= '0;
          end
        end
        S_LEN: begin
          if (w_accept && !w_len_bad) begin
            r_len      <= bus.ByteIn[IDX_W-1:0];
            r_word_idx <= '0;
            r_byte_cnt <= '0;
`ifdef PROGLOADER_CHECKSUM_EN
            r_xor      <= '0;
`endif
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_write_data[{r_byte_cnt, 3'b000} +: 8] <= bus.ByteIn;
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef PROGLOADER_CHECKSUM_EN
            r_xor      <= r_xor ^ bus.ByteIn;
`endif
          end
        end
        S_WRITE: begin
          r_word_idx <= w_idx_inc;
        end
        default: ;
      endcase
    end
  end

  assign bus.ByteReady    = w_byte_ready;
  assign bus.MemWrite     = w_mem_write;
  assign bus.WriteAddress = DATA_WIDTH'({r_word_idx, 2'b00});
  assign bus.WriteData    = r_write_data;
  assign bus.CpuHold      = w_cpu_hold;
  assign bus.Done         = w_done;
  assign bus.Error        = w_error;

endmodule

// File: doc/program_loader.md
# program_loader

Writer side of the instruction ROM: receives a program as a byte stream over a valid/ready handshake, assembles little-endian words and drives a sequential write port into the program memory array. The CPU is held while loading, and `Done`/`Error` are reported at the end. It sits between the host byte link (UART receiver or testbench) and the program memory write port. While `CpuHold` is high, the CPU fetch path must not read the array.

## Interface
- `MEMORY_DEPTH`, 32, number of words in program memory; maximum program length.
- `DATA_WIDTH`, 32, instruction/word width; fixed at 32 (4 bytes per word).
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `Start` input 1: one-cycle pulse that begins a load; honoured only in IDLE, DONE and ERROR.
- `ByteIn` input 8: stream data byte.
- `ByteValid` input 1: `ByteIn` is valid.
- `ByteReady` output 1: loader accepts a byte this cycle. A transfer occurs when `ByteValid && ByteReady`.
- `MemWrite` output 1: one-cycle write strobe to program memory.
- `WriteAddress` output DATA_WIDTH: byte address of the word being written; always `word_index << 2`.
- `WriteData` output DATA_WIDTH: assembled instruction word.
- `CpuHold` output 1: CPU must stall or stay in reset.
- `Done` output 1: load completed successfully; sticky.
- `Error` output 1: load aborted; sticky.

## Operation
- Stream format:
  - Length byte L: word count, valid range 1..MEMORY_DEPTH.
  - 4·L data bytes, least significant byte first.
  - Checksum byte, only when the checksum feature is enabled.
- States:
  - IDLE: entered on reset.
  - LEN: on `Start`, go to LEN. Accept one byte. If L = 0 or L > MEMORY_DEPTH, go to ERROR. Otherwise latch L, clear word index and byte counter, go to DATA.
  - DATA: accept bytes into `WriteData[8k+7:8k]` for k = 0..3. After the 4th byte, go to WRITE.
  - WRITE: assert `MemWrite` for one cycle with the current address and data, then increment the word index. If index = L, go to CHECK (checksum enabled) or DONE. Otherwise return to DATA.
  - CHECK: accept one byte, then go to DONE or ERROR.
  - DONE and ERROR: wait for `Start`, which re-enters LEN and clears `Done`/`Error`.
- `ByteReady` = 1 only in LEN, DATA and CHECK.
- `CpuHold` = 1 in LEN, DATA, WRITE, CHECK and ERROR; 0 in IDLE and DONE.
- `Done` = 1 only in DONE; `Error` = 1 only in ERROR.
- `Start` is ignored while in LEN, DATA, WRITE or CHECK.
- Words already written before an error or reset stay in memory. The loader never erases memory.

## Timing
- Reset values: state IDLE; `ByteReady` 0, `MemWrite` 0, `WriteAddress` 0, `WriteData` 0, `CpuHold` 0, `Done` 0, `Error` 0; all counters 0.
- Outputs are registered or decoded from state only; nothing depends combinationally on `ByteValid` or `ByteIn`.
- `Start` at edge n puts the loader in LEN, with `ByteReady` = 1 and `CpuHold` = 1 visible after edge n.
- Throughput: 4 accept cycles plus 1 WRITE cycle per word. With no gaps, a word is written 5 cycles after its first byte is accepted.
- `ByteValid` gaps stall DATA indefinitely; byte order and content are unaffected.
- After the final WRITE, `Done` is high on the next cycle (no checksum) or on the cycle after the checksum byte is accepted.
- If `reset` is asserted mid-load, the loader returns to IDLE immediately and asynchronously, and any partial word is discarded.

## Configuration
- Macro: `PROGLOADER_CHECKSUM_EN`.
- Defined:
  - Keep a running 8-bit XOR of all data bytes. The length byte is excluded.
  - After the last WRITE, enter CHECK and accept one byte.
  - If the byte equals the XOR, go to DONE; otherwise go to ERROR.
- Undefined:
  - No CHECK state and no XOR register.
  - The last WRITE goes directly to DONE, and the stream carries no trailing byte.

## Test plan
- Nominal load, checksum off: Start, stream 02, 20 00 08 24, 00 00 00 08 with no gaps.
  - Writes 0x24080020 at address 0 and 0x08000000 at address 4.
  - One-cycle `MemWrite` each; `Done`=1 and `CpuHold`=0 afterwards.
- Bad length: length byte 00, and separately 0x21 with MEMORY_DEPTH=32.
  - `Error`=1 and `CpuHold`=1, with no `MemWrite`.
  - The next `Start` clears `Error`.
- Checksum enabled, 1 word 11 22 33 44:
  - Trailer 0x44 (XOR of the four bytes) gives `Done`.
  - Trailer 0x45 gives `Error`, with the word already written at address 0.
- Backpressure: random 0–5 cycle `ByteValid` gaps over a 32-word load.
  - Memory contents match the stream.
  - Addresses run 0x00..0x7C.
  - `ByteReady`=0 during every WRITE cycle.
- Reset mid-load: assert `reset` after the 2nd byte of word 3.
  - All outputs 0 immediately, state IDLE.
  - Words 0–2 remain in memory.
  - A subsequent `Start` reloads from address 0.
- `Start` pulsed during DATA is ignored: byte and word counters continue and the load completes normally.
